// File: rtl/silencer_update_scheduler_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package   : settings                                                      |
// | Purpose   : Silencer settings type, scheduler state enum, reset defaults  |
// | Revision  : 1.0                                                           |
// +----------------------------------------------------------------------------+
package settings;

    typedef struct packed {
        logic [7:0]  FLAG;
        logic [15:0] COMPLETION_STEPS_INTENSITY;
        logic [15:0] COMPLETION_STEPS_PHASE;
    } silencer_settings_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } sched_state_t;

    localparam silencer_settings_t c_SETTINGS_DEFAULT = '{
        FLAG                       : 8'd0,
        COMPLETION_STEPS_INTENSITY : 16'd1,
        COMPLETION_STEPS_PHASE     : 16'd1
    };

    // A zero step count would stall the silencer forever, so it is promoted to 1.
    function automatic silencer_settings_t clamp_steps(input silencer_settings_t s);
        silencer_settings_t r;
        r = s;
        if (s.COMPLETION_STEPS_INTENSITY == 16'd0) begin
            r.COMPLETION_STEPS_INTENSITY = 16'd1;
        end
        if (s.COMPLETION_STEPS_PHASE == 16'd0) begin
            r.COMPLETION_STEPS_PHASE = 16'd1;
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/silencer_update_scheduler_settings_latch.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : silencer_settings_latch                                       |
// | Purpose   : Pending settings register, step clamp, apply-only-in-IDLE     |
// | Revision  : 1.0                                                           |
// +----------------------------------------------------------------------------+
module silencer_settings_latch
    import settings::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_settings_we,
    input  silencer_settings_t i_settings_in,
    input  logic               i_idle,
    output silencer_settings_t o_settings
);

    silencer_settings_t r_pending;
    silencer_settings_t r_applied;
    logic               r_pend_valid;
    silencer_settings_t w_next;

    // A write landing on an IDLE edge bypasses the pending register entirely.
    assign w_next = clamp_steps(i_settings_we ? i_settings_in : r_pending);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_pending    <= c_SETTINGS_DEFAULT;
            r_pend_valid <= 1'b0;
            r_applied    <= c_SETTINGS_DEFAULT;
        end else if (i_idle && (i_settings_we || r_pend_valid)) begin
            r_applied    <= w_next;
            r_pend_valid <= 1'b0;
        end else if (i_settings_we) begin
            r_pending    <= i_settings_in;
            r_pend_valid <= 1'b1;
        end
    end

    assign o_settings = r_applied;

endmodule
`default_nettype wire

// File: rtl/silencer_update_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : silencer_update_scheduler                                     |
// | Purpose   : Streams one DEPTH-entry burst into the silencer per UPDATE.   |
// |             Define SILENCER_SCHED_OVERRUN_CNT_EN to count dropped updates.|
// | Revision  : 1.0                                                           |
// +----------------------------------------------------------------------------+
module silencer_update_scheduler
    import settings::*;
#(
    parameter int DEPTH         = 249,
    parameter int DRAIN_TIMEOUT = 1024
) (
    input  logic                     CLK,
    input  logic                     RESET_N,
    input  logic                     UPDATE,
    input  logic                     SETTINGS_WE,
    input  silencer_settings_t       SETTINGS_IN,
    output logic [$clog2(DEPTH)-1:0] RADDR,
    input  logic [7:0]               RDATA_INTENSITY,
    input  logic [7:0]               RDATA_PHASE,
    output logic                     DIN_VALID,
    output logic [7:0]               INTENSITY,
    output logic [7:0]               PHASE,
    output silencer_settings_t       SILENCER_SETTINGS,
    input  logic                     DOUT_VALID,
    output logic                     BUSY,
    output logic                     TIMEOUT_ERR,
    output logic [7:0]               OVERRUN_CNT
);

    localparam int              c_AW         = $clog2(DEPTH);
    localparam int              c_DW         = $clog2(DRAIN_TIMEOUT + 1);
    localparam logic [c_AW-1:0] c_LAST_ADDR  = c_AW'(DEPTH - 1);
    localparam logic [c_DW-1:0] c_LAST_DRAIN = c_DW'(DRAIN_TIMEOUT - 1);

    sched_state_t    r_state;
    logic [c_AW-1:0] r_raddr;
    logic            r_rd_valid;
    logic            r_din_valid;
    logic [7:0]      r_intensity;
    logic [7:0]      r_phase;
    logic            r_busy;
    logic            r_timeout_err;
    logic            r_dout_seen;
    logic [c_DW-1:0] r_drain_cnt;
    logic            r_upd_pend;
    logic            w_idle;
    logic            w_start;

    assign w_idle  = (r_state == IDLE);
    assign w_start = w_idle && (UPDATE || r_upd_pend);

    // r_rd_valid marks that RDATA after this edge belongs to the burst; it
    // re-times with the memory's one-cycle latency so DIN_VALID aligns with data.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state       <= IDLE;
            r_raddr       <= '0;
            r_rd_valid    <= 1'b0;
            r_din_valid   <= 1'b0;
            r_intensity   <= 8'd0;
            r_phase       <= 8'd0;
            r_busy        <= 1'b0;
            r_timeout_err <= 1'b0;
            r_dout_seen   <= 1'b0;
            r_drain_cnt   <= '0;
        end else begin
            r_rd_valid  <= 1'b0;
            r_din_valid <= r_rd_valid;
            if (r_rd_valid) begin
                r_intensity <= RDATA_INTENSITY;
                r_phase     <= RDATA_PHASE;
            end
            case (r_state)
                IDLE: begin
                    if (w_start) begin
                        r_state     <= READ;
                        r_raddr     <= '0;
                        r_busy      <= 1'b1;
                        r_dout_seen <= 1'b0;
                    end
                end
                READ: begin
                    r_rd_valid <= 1'b1;
                    if (DOUT_VALID) begin
                        r_dout_seen <= 1'b1;
                    end
                    if (r_raddr == c_LAST_ADDR) begin
                        r_state     <= DRAIN;
                        r_raddr     <= '0;
                        r_drain_cnt <= '0;
                    end else begin
                        r_raddr <= r_raddr + c_AW'(1);
                    end
                end
                DRAIN: begin
                    if (DOUT_VALID) begin
                        r_dout_seen <= 1'b1;
                    end
                    if (r_dout_seen && !DOUT_VALID) begin
                        r_state <= IDLE;
                        r_busy  <= 1'b0;
                    end else if (r_drain_cnt == c_LAST_DRAIN) begin
                        r_state       <= IDLE;
                        r_busy        <= 1'b0;
                        r_timeout_err <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + c_DW'(1);
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // The pending update is consumed by the first IDLE edge, which also starts it.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_upd_pend <= 1'b0;
        end else if (w_idle) begin
            r_upd_pend <= 1'b0;
        end else if (UPDATE) begin
            r_upd_pend <= 1'b1;
        end
    end

`ifdef SILENCER_SCHED_OVERRUN_CNT_EN
    logic       w_update_drop;
    logic [7:0] r_overrun_cnt;

    assign w_update_drop = UPDATE && !w_idle && r_upd_pend;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_overrun_cnt <= 8'd0;
        end else if (w_update_drop && (r_overrun_cnt != 8'hFF)) begin
            r_overrun_cnt <= r_overrun_cnt + 8'd1;
        end
    end

    assign OVERRUN_CNT = r_overrun_cnt;
`else
    assign OVERRUN_CNT = 8'd0;
`endif

    silencer_settings_latch u_settings_latch (
        .i_clk         (CLK),
        .i_rst_n       (RESET_N),
        .i_settings_we (SETTINGS_WE),
        .i_settings_in (SETTINGS_IN),
        .i_idle        (w_idle),
        .o_settings    (SILENCER_SETTINGS)
    );

    assign RADDR       = r_raddr;
    assign DIN_VALID   = r_din_valid;
    assign INTENSITY   = r_intensity;
    assign PHASE       = r_phase;
    assign BUSY        = r_busy;
    assign TIMEOUT_ERR = r_timeout_err;

endmodule
`default_nettype wire

// File: tb/tb_silencer_update_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module    : tb_silencer_update_scheduler                                  |
// | Purpose   : Directed self-checking bench for silencer_update_scheduler    |
// | Revision  : 1.0                                                           |
// +----------------------------------------------------------------------------+
module tb_silencer_update_scheduler;
    import settings::*;

    localparam int DEPTH         = 249;
    localparam int DRAIN_TIMEOUT = 1024;
`ifdef SILENCER_SCHED_OVERRUN_CNT_EN
    localparam bit OVR_EN = 1'b1;
`else
    localparam bit OVR_EN = 1'b0;
`endif

    logic               CLK         = 1'b0;
    logic               RESET_N     = 1'b0;
    logic               UPDATE      = 1'b0;
    logic               SETTINGS_WE = 1'b0;
    silencer_settings_t SETTINGS_IN = '0;
    logic [7:0]         RADDR;
    logic [7:0]         RDATA_INTENSITY;
    logic [7:0]         RDATA_PHASE;
    logic               DIN_VALID;
    logic [7:0]         INTENSITY;
    logic [7:0]         PHASE;
    silencer_settings_t SILENCER_SETTINGS;
    logic               DOUT_VALID;
    logic               BUSY;
    logic               TIMEOUT_ERR;
    logic [7:0]         OVERRUN_CNT;

    logic       dout_follow = 1'b1;
    logic [7:0] mem_int [256];
    logic [7:0] mem_ph  [256];
    int         vec_cnt = 0;
    int         err_cnt = 0;

    silencer_settings_t exp_def = '{FLAG: 8'd0, COMPLETION_STEPS_INTENSITY: 16'd1,
                                    COMPLETION_STEPS_PHASE: 16'd1};

    silencer_update_scheduler #(.DEPTH(DEPTH), .DRAIN_TIMEOUT(DRAIN_TIMEOUT)) dut (
        .CLK               (CLK),
        .RESET_N           (RESET_N),
        .UPDATE            (UPDATE),
        .SETTINGS_WE       (SETTINGS_WE),
        .SETTINGS_IN       (SETTINGS_IN),
        .RADDR             (RADDR),
        .RDATA_INTENSITY   (RDATA_INTENSITY),
        .RDATA_PHASE       (RDATA_PHASE),
        .DIN_VALID         (DIN_VALID),
        .INTENSITY         (INTENSITY),
        .PHASE             (PHASE),
        .SILENCER_SETTINGS (SILENCER_SETTINGS),
        .DOUT_VALID        (DOUT_VALID),
        .BUSY              (BUSY),
        .TIMEOUT_ERR       (TIMEOUT_ERR),
        .OVERRUN_CNT       (OVERRUN_CNT)
    );

    always #5 CLK = ~CLK;

    // Source memory with one-cycle read latency; silencer echoes its input valid.
    always @(posedge CLK) begin
        RDATA_INTENSITY <= mem_int[RADDR];
        RDATA_PHASE     <= mem_ph[RADDR];
    end
    assign DOUT_VALID = dout_follow & DIN_VALID;

    task automatic load_mem(input logic [7:0] ph_xor);
        for (int i = 0; i < 256; i++) begin
            mem_int[i] = 8'(i);
            mem_ph[i]  = 8'(i) ^ ph_xor;
        end
    endtask

    task automatic pulse_update();
        UPDATE = 1'b1;
        @(negedge CLK);
        UPDATE = 1'b0;
    endtask

    task automatic write_settings(input logic [7:0] flag, input logic [15:0] si,
                                  input logic [15:0] sp);
        SETTINGS_IN = '{FLAG: flag, COMPLETION_STEPS_INTENSITY: si, COMPLETION_STEPS_PHASE: sp};
        SETTINGS_WE = 1'b1;
        @(negedge CLK);
        SETTINGS_WE = 1'b0;
    endtask

    task automatic wait_idle(input int limit);
        int n;
        n = 0;
        while (BUSY === 1'b1 && n < limit) begin
            @(negedge CLK);
            n++;
        end
        vec_cnt++;
        if (BUSY !== 1'b0) begin
            err_cnt++;
            $display("FAIL wait_idle: BUSY=%b after %0d cycles, required 0", BUSY, n);
        end
    endtask

    // Entered one half-cycle after the edge that sampled UPDATE; DOUT follows DIN.
    task automatic check_burst(input logic [7:0] ph_xor, input string tag);
        logic [7:0] e;
        vec_cnt++;
        if (BUSY !== 1'b1 || RADDR !== 8'd0 || DIN_VALID !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s_start: BUSY=%b RADDR=%0d DIN_VALID=%b, required 1/0/0",
                     tag, BUSY, RADDR, DIN_VALID);
        end
        @(negedge CLK);
        vec_cnt++;
        if (DIN_VALID !== 1'b0 || RADDR !== 8'd1) begin
            err_cnt++;
            $display("FAIL %s_lat: DIN_VALID=%b RADDR=%0d, required 0/1", tag, DIN_VALID, RADDR);
        end
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge CLK);
            e = 8'(i);
            vec_cnt++;
            if (DIN_VALID !== 1'b1 || INTENSITY !== e || PHASE !== (e ^ ph_xor)) begin
                err_cnt++;
                $display("FAIL %s_data[%0d]: valid=%b int=%h ph=%h, required 1/%h/%h",
                         tag, i, DIN_VALID, INTENSITY, PHASE, e, e ^ ph_xor);
            end
        end
        @(negedge CLK);
        vec_cnt++;
        if (DIN_VALID !== 1'b0 || BUSY !== 1'b1) begin
            err_cnt++;
            $display("FAIL %s_end: DIN_VALID=%b BUSY=%b, required 0/1", tag, DIN_VALID, BUSY);
        end
        @(negedge CLK);
        vec_cnt++;
        if (BUSY !== 1'b0) begin
            err_cnt++;
            $display("FAIL %s_idle: BUSY=%b, required 0", tag, BUSY);
        end
    endtask

    task automatic check_reset_values(input string tag);
        vec_cnt++;
        if (BUSY !== 1'b0 || DIN_VALID !== 1'b0 || RADDR !== 8'd0 || INTENSITY !== 8'd0 ||
            PHASE !== 8'd0 || TIMEOUT_ERR !== 1'b0 || OVERRUN_CNT !== 8'd0) begin
            err_cnt++;
            $display("FAIL %s: busy=%b dv=%b ra=%0d int=%h ph=%h to=%b ovr=%0d, required all 0",
                     tag, BUSY, DIN_VALID, RADDR, INTENSITY, PHASE, TIMEOUT_ERR, OVERRUN_CNT);
        end
        vec_cnt++;
        if (SILENCER_SETTINGS !== exp_def) begin
            err_cnt++;
            $display("FAIL %s_settings: got %h required %h", tag, SILENCER_SETTINGS, exp_def);
        end
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        repeat (2) @(negedge CLK);
        check_reset_values("reset");
        RESET_N = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_burst();
        load_mem(8'h00);
        dout_follow = 1'b1;
        pulse_update();
        check_burst(8'h00, "ramp");
    endtask

    task automatic test_settings_midread();
        silencer_settings_t exp_new;
        exp_new = '{FLAG: 8'hA1, COMPLETION_STEPS_INTENSITY: 16'd10, COMPLETION_STEPS_PHASE: 16'd10};
        pulse_update();
        repeat (10) @(negedge CLK);
        write_settings(8'hEE, 16'd99, 16'd99);
        repeat (5) @(negedge CLK);
        write_settings(8'hA1, 16'd10, 16'd10);
        vec_cnt++;
        if (SILENCER_SETTINGS !== exp_def) begin
            err_cnt++;
            $display("FAIL mid_read_hold: got %h required %h", SILENCER_SETTINGS, exp_def);
        end
        wait_idle(400);
        vec_cnt++;
        if (SILENCER_SETTINGS !== exp_def) begin
            err_cnt++;
            $display("FAIL drain_exit_hold: got %h required %h", SILENCER_SETTINGS, exp_def);
        end
        @(negedge CLK);
        vec_cnt++;
        if (SILENCER_SETTINGS !== exp_new) begin
            err_cnt++;
            $display("FAIL idle_apply: got %h required %h", SILENCER_SETTINGS, exp_new);
        end
        write_settings(8'h5A, 16'd0, 16'd7);
        vec_cnt++;
        if (SILENCER_SETTINGS !== 40'h5A_0001_0007) begin
            err_cnt++;
            $display("FAIL clamp_int: got %h required %h", SILENCER_SETTINGS, 40'h5A_0001_0007);
        end
        write_settings(8'h07, 16'd3, 16'd0);
        vec_cnt++;
        if (SILENCER_SETTINGS !== 40'h07_0003_0001) begin
            err_cnt++;
            $display("FAIL clamp_ph: got %h required %h", SILENCER_SETTINGS, 40'h07_0003_0001);
        end
    endtask

    task automatic test_settings_with_update();
        SETTINGS_IN = '{FLAG: 8'h33, COMPLETION_STEPS_INTENSITY: 16'd20, COMPLETION_STEPS_PHASE: 16'd30};
        SETTINGS_WE = 1'b1;
        UPDATE      = 1'b1;
        @(negedge CLK);
        SETTINGS_WE = 1'b0;
        UPDATE      = 1'b0;
        vec_cnt++;
        if (SILENCER_SETTINGS !== 40'h33_0014_001E) begin
            err_cnt++;
            $display("FAIL same_edge_apply: got %h required %h", SILENCER_SETTINGS, 40'h33_0014_001E);
        end
        check_burst(8'h00, "upd_settings");
    endtask

    task automatic test_overrun();
        int   rises;
        int   din_cnt;
        int   quiet;
        logic prev;
        RESET_N = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        rises   = 0;
        din_cnt = 0;
        quiet   = 0;
        prev    = 1'b0;
        pulse_update();
        for (int c = 1; c <= 3000 && quiet < 20; c++) begin
            UPDATE = (c == 10 || c == 20);
            @(negedge CLK);
            if (DIN_VALID === 1'b1 && prev !== 1'b1) rises++;
            if (DIN_VALID === 1'b1) din_cnt++;
            prev  = DIN_VALID;
            quiet = (BUSY === 1'b1) ? 0 : quiet + 1;
        end
        UPDATE = 1'b0;
        vec_cnt++;
        if (rises !== 2 || din_cnt !== 2 * DEPTH) begin
            err_cnt++;
            $display("FAIL followup: bursts=%0d valid_cycles=%0d, required 2/%0d", rises, din_cnt, 2 * DEPTH);
        end
        vec_cnt++;
        if (OVERRUN_CNT !== (OVR_EN ? 8'd1 : 8'd0)) begin
            err_cnt++;
            $display("FAIL overrun_one: got %0d required %0d", OVERRUN_CNT, OVR_EN ? 1 : 0);
        end
    endtask

    task automatic test_timeout();
        RESET_N = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        dout_follow = 1'b0;
        pulse_update();
        for (int k = 1; k <= DEPTH + DRAIN_TIMEOUT - 1; k++) begin
            UPDATE = (k <= 301);
            @(negedge CLK);
        end
        UPDATE = 1'b0;
        vec_cnt++;
        if (BUSY !== 1'b1 || TIMEOUT_ERR !== 1'b0) begin
            err_cnt++;
            $display("FAIL pre_timeout: BUSY=%b TIMEOUT_ERR=%b, required 1/0", BUSY, TIMEOUT_ERR);
        end
        vec_cnt++;
        if (OVERRUN_CNT !== (OVR_EN ? 8'd255 : 8'd0)) begin
            err_cnt++;
            $display("FAIL overrun_sat: got %0d required %0d", OVERRUN_CNT, OVR_EN ? 255 : 0);
        end
        @(negedge CLK);
        vec_cnt++;
        if (BUSY !== 1'b0 || TIMEOUT_ERR !== 1'b1) begin
            err_cnt++;
            $display("FAIL timeout_exit: BUSY=%b TIMEOUT_ERR=%b, required 0/1", BUSY, TIMEOUT_ERR);
        end
        @(negedge CLK);
        vec_cnt++;
        if (BUSY !== 1'b1) begin
            err_cnt++;
            $display("FAIL pending_start: BUSY=%b, required 1", BUSY);
        end
        wait_idle(DEPTH + DRAIN_TIMEOUT + 10);
        vec_cnt++;
        if (TIMEOUT_ERR !== 1'b1) begin
            err_cnt++;
            $display("FAIL timeout_sticky: got %b required 1", TIMEOUT_ERR);
        end
        dout_follow = 1'b1;
        @(negedge CLK);
        pulse_update();
        check_burst(8'h00, "post_timeout");
    endtask

    task automatic test_reset_midburst();
        write_settings(8'hC3, 16'd40, 16'd50);
        load_mem(8'h3C);
        pulse_update();
        repeat (102) @(negedge CLK);
        vec_cnt++;
        if (DIN_VALID !== 1'b1 || INTENSITY !== 8'd100) begin
            err_cnt++;
            $display("FAIL cycle100: valid=%b int=%0d, required 1/100", DIN_VALID, INTENSITY);
        end
        RESET_N = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(negedge CLK);
        RESET_N = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge CLK);
            vec_cnt++;
            if (DIN_VALID !== 1'b0 || BUSY !== 1'b0) begin
                err_cnt++;
                $display("FAIL no_resume[%0d]: DIN_VALID=%b BUSY=%b, required 0/0", k, DIN_VALID, BUSY);
            end
        end
        pulse_update();
        check_burst(8'h3C, "after_reset");
    endtask

    initial begin
        load_mem(8'h00);
        test_reset();
        test_burst();
        test_settings_midread();
        test_settings_with_update();
        test_overrun();
        test_timeout();
        test_reset_midburst();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
